// File: rtl/fpu_share_pkg.sv
// Shared types, widths and helpers for the FPU share arbiter.
package fpu_share_pkg;

    localparam int PERF_CNT_WIDTH = 32;
    localparam int CNT_WIDTH      = 4;

    // Arbiter lock state: OPEN searches round-robin, LOCKED holds the
    // request that the FPU has seen but not yet accepted.
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of a requester index, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fpu_share_rr_arb.sv
// Round-robin winner search with a grant lock.
// The search starts at rr_ptr and wraps. Once a request has been shown to the
// FPU without a grant, the winner is frozen until the handshake completes or
// the locked requester withdraws. state_q is the lock FSM state.
module fpu_share_rr_arb
    import fpu_share_pkg::*;
#(
    parameter int NB_CORES = 4,
    parameter int IDX_BITS = idx_bits(NB_CORES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NB_CORES-1:0] elig,
    input  logic                hs,
    output logic [IDX_BITS-1:0] winner_idx,
    output logic                valid
);

    arb_state_e          state_q, state_d;
    logic [IDX_BITS-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;

    logic                scan_found;
    logic [IDX_BITS-1:0] scan_idx;

    // Priority search: first eligible at or above rr_ptr, then wrap to the bottom.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            if (!scan_found && elig[i] && (IDX_BITS'(i) >= rr_ptr_q)) begin
                scan_found = 1'b1;
                scan_idx   = IDX_BITS'(i);
            end
        end
        for (int i = 0; i < NB_CORES; i++) begin
            if (!scan_found && elig[i] && (IDX_BITS'(i) < rr_ptr_q)) begin
                scan_found = 1'b1;
                scan_idx   = IDX_BITS'(i);
            end
        end
    end

    // Output decode: the locked requester overrides the search result.
    always_comb begin
        winner_idx = scan_idx;
        valid      = scan_found;
        if (state_q == ARB_LOCKED) begin
            winner_idx = lock_idx_q;
            valid      = elig[lock_idx_q];
        end
    end

    // Next-state: lock on an unaccepted request, release on handshake or withdrawal.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            ARB_OPEN: begin
                if (valid && !hs) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = winner_idx;
                end
            end
            ARB_LOCKED: begin
                if (hs || !valid) begin
                    state_d = ARB_OPEN;
                end
            end
            default: state_d = ARB_OPEN;
        endcase
        if (hs) begin
            rr_ptr_d = (winner_idx == IDX_BITS'(NB_CORES - 1)) ? '0 : winner_idx + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_OPEN;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one FPU among NB_CORES requesters: round-robin arbitration with a
// grant lock, per-requester credit limiting, requester index prepended to the
// FPU-side ID, responses routed back by that index.
// Optional feature macro: FPU_SHARE_PERF_EN (per-requester grant/stall counters).
//
// Request handshake: a requester raises core_req_i with its payload and holds
// both until core_gnt_o is seen high in the same cycle; the transfer happens in
// exactly that cycle, which is also the cycle where fpu_req_o & fpu_gnt_i.
// The response channel has no backpressure: fpu_rvalid_i is a one-cycle pulse
// and the matching core_rvalid_o bit is raised in that same cycle.
module fpu_share_arbiter
    import fpu_share_pkg::*;
#(
    parameter int NB_CORES        = 4,
    parameter int CORE_ID_WIDTH   = 7,
    parameter int IDX_BITS        = idx_bits(NB_CORES),
    parameter int ID_WIDTH        = CORE_ID_WIDTH + IDX_BITS,
    parameter int NB_ARGS         = 3,
    parameter int OPCODE_WIDTH    = 6,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NB_CORES-1:0]                    core_req_i,
    output logic [NB_CORES-1:0]                    core_gnt_o,
    input  logic [NB_CORES*CORE_ID_WIDTH-1:0]      core_ID_i,
    input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0] core_operands_i,
    input  logic [NB_CORES*OPCODE_WIDTH-1:0]       core_op_i,
    input  logic [NB_CORES*FLAGS_IN_WIDTH-1:0]     core_flags_i,
    output logic [NB_CORES-1:0]                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  core_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]             core_rflags_o,
    output logic [CORE_ID_WIDTH-1:0]               core_rID_o,
    output logic                                   fpu_req_o,
    input  logic                                   fpu_gnt_i,
    output logic [ID_WIDTH-1:0]                    fpu_ID_o,
    output logic [NB_ARGS*DATA_WIDTH-1:0]          fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                fpu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]              fpu_flags_o,
    input  logic                                   fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  fpu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]             fpu_rflags_i,
    input  logic [ID_WIDTH-1:0]                    fpu_rID_i,
    output logic                                   spurious_rsp_o,
    output logic [NB_CORES*PERF_CNT_WIDTH-1:0]     perf_grant_cnt_o,
    output logic [NB_CORES*PERF_CNT_WIDTH-1:0]     perf_stall_cnt_o
);

    localparam int OPND_W = NB_ARGS * DATA_WIDTH;

    logic [CNT_WIDTH-1:0] cnt_q [NB_CORES];
    logic [CNT_WIDTH-1:0] cnt_d [NB_CORES];
    logic                 spurious_q, spurious_d;

    logic [NB_CORES-1:0]  elig;
    logic [NB_CORES-1:0]  issue;
    logic [NB_CORES-1:0]  rsp_hit;
    logic [IDX_BITS-1:0]  winner_idx;
    logic                 arb_valid;
    logic                 hs;
    logic [IDX_BITS-1:0]  rsp_idx;

    // A requester competes only while it still has credit left.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            elig[i] = core_req_i[i] && (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
    end

    fpu_share_rr_arb #(
        .NB_CORES (NB_CORES),
        .IDX_BITS (IDX_BITS)
    ) u_rr_arb (
        .clk        (clk),
        .rst        (rst),
        .elig       (elig),
        .hs         (hs),
        .winner_idx (winner_idx),
        .valid      (arb_valid)
    );

    assign fpu_req_o = arb_valid;
    assign hs        = arb_valid & fpu_gnt_i;

    // Payload mux and ID insertion; everything reads zero when nobody wins.
    always_comb begin
        fpu_ID_o       = '0;
        fpu_operands_o = '0;
        fpu_op_o       = '0;
        fpu_flags_o    = '0;
        core_gnt_o     = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            if (arb_valid && (winner_idx == IDX_BITS'(i))) begin
                fpu_ID_o       = {IDX_BITS'(i), core_ID_i[i*CORE_ID_WIDTH +: CORE_ID_WIDTH]};
                fpu_operands_o = core_operands_i[i*OPND_W +: OPND_W];
                fpu_op_o       = core_op_i[i*OPCODE_WIDTH +: OPCODE_WIDTH];
                fpu_flags_o    = core_flags_i[i*FLAGS_IN_WIDTH +: FLAGS_IN_WIDTH];
                core_gnt_o[i]  = fpu_gnt_i;
            end
        end
    end

    assign issue = core_gnt_o;

    // Response routing: accept only when the owning requester has work in flight.
    assign rsp_idx = fpu_rID_i[ID_WIDTH-1 -: IDX_BITS];
    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            rsp_hit[i] = fpu_rvalid_i && (rsp_idx == IDX_BITS'(i)) && (cnt_q[i] != '0);
        end
    end

    assign core_rvalid_o  = rsp_hit;
    assign core_rdata_o   = fpu_rdata_i;
    assign core_rflags_o  = fpu_rflags_i;
    assign core_rID_o     = fpu_rID_i[CORE_ID_WIDTH-1:0];
    assign spurious_rsp_o = spurious_q;

    // Credit bookkeeping: issue and retire in the same cycle cancel out.
    always_comb begin
        for (int i = 0; i < NB_CORES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (issue[i] && !rsp_hit[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!issue[i] && rsp_hit[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        spurious_d = spurious_q | (fpu_rvalid_i & ~(|rsp_hit));
    end

    // Credit counters and sticky spurious-response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_CORES; i++) begin
                cnt_q[i] <= '0;
            end
            spurious_q <= 1'b0;
        end else begin
            for (int i = 0; i < NB_CORES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            spurious_q <= spurious_d;
        end
    end

`ifdef FPU_SHARE_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] perf_grant_q [NB_CORES];
    logic [PERF_CNT_WIDTH-1:0] perf_grant_d [NB_CORES];
    logic [PERF_CNT_WIDTH-1:0] perf_stall_q [NB_CORES];
    logic [PERF_CNT_WIDTH-1:0] perf_stall_d [NB_CORES];

    // Saturating grant and stall counters per requester.
    always_comb begin
        for (int i = 0; i < NB_CORES; i++) begin
            perf_grant_d[i] = perf_grant_q[i];
            perf_stall_d[i] = perf_stall_q[i];
            if (issue[i] && (perf_grant_q[i] != '1)) begin
                perf_grant_d[i] = perf_grant_q[i] + 1'b1;
            end
            if (core_req_i[i] && !core_gnt_o[i] && (perf_stall_q[i] != '1)) begin
                perf_stall_d[i] = perf_stall_q[i] + 1'b1;
            end
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_CORES; i++) begin
                perf_grant_q[i] <= '0;
                perf_stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_CORES; i++) begin
                perf_grant_q[i] <= perf_grant_d[i];
                perf_stall_q[i] <= perf_stall_d[i];
            end
        end
    end

    // Flatten counters onto the output buses.
    always_comb begin
        perf_grant_cnt_o = '0;
        perf_stall_cnt_o = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            perf_grant_cnt_o[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] = perf_grant_q[i];
            perf_stall_cnt_o[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] = perf_stall_q[i];
        end
    end
`else
    assign perf_grant_cnt_o = '0;
    assign perf_stall_cnt_o = '0;
`endif

endmodule
